// File: rtl/uart_tx.sv
// uart_tx: byte-parallel to serial 8N1 transmitter with a small byte FIFO.
// Bytes enter over a valid/ready handshake and leave LSB-first on an idle-high line.
module uart_tx #(
    parameter logic [23:0] baud_rate  = 24'd2000000,
    parameter logic [27:0] clock_freq = 28'd100000000,
    parameter int unsigned fifo_depth = 4
) (
    input  logic       uart_clock,
    input  logic       uart_reset,
    input  logic [7:0] uart_d_in,
    input  logic       uart_d_valid,
    output logic       uart_ready,
    output logic       uart_d_out,
    output logic       uart_busy,
    output logic [4:0] uart_fifo_count
);

    // Clock cycles per serial bit.
    localparam logic [23:0] P      = 24'(clock_freq / 28'(baud_rate));
    localparam logic [23:0] P_LAST = P - 24'd1;
    localparam int unsigned AW     = $clog2(fifo_depth);
    localparam logic [4:0]  DEPTH  = 5'(fifo_depth);

    // Reject bit periods shorter than two clocks and unsupported FIFO sizes.
    if (P < 24'd2 || fifo_depth < 2 || fifo_depth > 16 ||
        (fifo_depth & (fifo_depth - 1)) != 0) begin : g_param_check
        $error("uart_tx: invalid parameters (need P >= 2, fifo_depth power of two in 2..16)");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [23:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            d_out_q, d_out_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic [4:0]      count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [fifo_depth];

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            cnt_last;

    // Next-state, FIFO bookkeeping and registered-output values.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        d_out_d    = d_out_q;
        pop        = 1'b0;
        push       = uart_d_valid && ready_q;
        fifo_empty = (count_q == 5'd0);
        cnt_last   = (clk_cnt_q == P_LAST);

        case (state_q)
            S_IDLE: begin
                d_out_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    d_out_d   = 1'b0;
                    clk_cnt_d = 24'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (cnt_last) begin
                    clk_cnt_d = 24'd0;
                    d_out_d   = shift_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 24'd1;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    clk_cnt_d = 24'd0;
                    if (bit_cnt_q == 3'd7) begin
                        d_out_d = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        d_out_d   = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 24'd1;
                end
            end
            S_STOP: begin
                if (cnt_last) begin
                    clk_cnt_d = 24'd0;
                    if (!fifo_empty) begin
                        // Back-to-back frame: next start bit follows the stop bit directly.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        d_out_d = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                d_out_d = 1'b1;
            end
        endcase

        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        ready_d = (count_d != DEPTH);
        busy_d  = (state_d != S_IDLE) || (count_d != 5'd0);
    end

    // State, counters, pointers and outputs; reset returns the line high at once.
    always_ff @(posedge uart_clock or posedge uart_reset) begin
        if (uart_reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= 24'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            d_out_q   <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            count_q   <= 5'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            d_out_q   <= d_out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge uart_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uart_d_in;
        end
    end

    assign uart_ready      = ready_q;
    assign uart_d_out      = d_out_q;
    assign uart_busy       = busy_q;
    assign uart_fifo_count = count_q;

endmodule
